// File: rtl/pipelined_csa_multiplier.sv
// pipelined_csa_multiplier: iterative WIDTH x WIDTH multiplier.
// Partial-product rows are folded into a carry-save (sum, carry) pair,
// ROWS_PER_CYCLE rows per RUN cycle, then resolved by one final add.
// Valid/ready handshake on operands and product.
// Optional macro MULT_SIGNED_EN adds signed_mode (two's complement, Baugh-Wooley).
module pipelined_csa_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy
`ifdef MULT_SIGNED_EN
  ,
  input  logic                 signed_mode
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + ROWS_PER_CYCLE) + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] TOP_BIT  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LOW_BITS = ~TOP_BIT;
  localparam logic [PW-1:0]    BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  generate
    if (ROWS_PER_CYCLE < 1 || ROWS_PER_CYCLE > WIDTH) begin : g_bad_rows
      $error("ROWS_PER_CYCLE must be in 1..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [PW-1:0]     sum, carry;
  logic [PW-1:0]     sum_nx, carry_nx;
  logic [IW-1:0]     idx;
  logic              sgn_r;
  logic              last_run;

  logic [PW-1:0]     s_acc, c_acc, pp, t;
  logic [WIDTH-1:0]  rbits;
  int unsigned       r;

`ifndef MULT_SIGNED_EN
  // Unsigned-only build: sign handling is permanently off.
  always_comb sgn_r = 1'b0;
`endif

  assign last_run = (32'(idx) + ROWS_PER_CYCLE) >= WIDTH;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (last_run) state_nx = ADD;
      ADD:  state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One RUN step: chain of ROWS_PER_CYCLE 3:2 compressors over rows idx..idx+R-1.
  // Baugh-Wooley correction constant replaces the (zero) sum on the first step.
  always_comb begin
    s_acc = (sgn_r && idx == '0) ? BW_CONST : sum;
    c_acc = carry;
    pp    = '0;
    t     = '0;
    rbits = '0;
    r     = 0;
    for (int unsigned j = 0; j < ROWS_PER_CYCLE; j++) begin
      r  = 32'(idx) + j;
      pp = '0;
      if (r < WIDTH) begin
        rbits = a_r & {WIDTH{b_r[r[BW-1:0]]}};
        if (sgn_r) rbits = rbits ^ ((r == WIDTH - 1) ? LOW_BITS : TOP_BIT);
        pp = {{WIDTH{1'b0}}, rbits} << r;
      end
      t     = s_acc ^ c_acc ^ pp;
      c_acc = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
      s_acc = t;
    end
    sum_nx   = s_acc;
    carry_nx = c_acc;
  end

  // Datapath registers: operand capture, carry-save accumulation, final add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      carry <= '0;
      idx   <= '0;
      prod  <= '0;
`ifdef MULT_SIGNED_EN
      sgn_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          sum   <= '0;
          carry <= '0;
          idx   <= '0;
`ifdef MULT_SIGNED_EN
          sgn_r <= signed_mode;
`endif
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= carry_nx;
          idx   <= idx + IW'(ROWS_PER_CYCLE);
        end
        ADD:     prod <= sum + carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_csa_multiplier.sv
// Bench for pipelined_csa_multiplier: 8x8 (R=2) and 16x16 (R=3) instances
// checked against plain-arithmetic products and latency K+1 = ceil(W/R)+1.
module tb_pipelined_csa_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

`ifdef MULT_SIGNED_EN
  logic        sm8, sm16;
`endif

  int checks = 0;
  int errors = 0;

  localparam int LAT8  = (8 + 2 - 1) / 2 + 1;
  localparam int LAT16 = (16 + 3 - 1) / 3 + 1;

  always #5 clk = ~clk;

  pipelined_csa_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .prod(prod8), .busy(busy8)
`ifdef MULT_SIGNED_EN
    , .signed_mode(sm8)
`endif
  );

  pipelined_csa_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .prod(prod16), .busy(busy16)
`ifdef MULT_SIGNED_EN
    , .signed_mode(sm16)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8-bit unit, return product and accept-to-valid latency (-1 on timeout).
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p, output int lat);
    int n = 0;
    while (!in_ready8 && n < 50) begin tick(); n++; end
    a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid8) begin lat = i; break; end
    end
    p = prod8;
    tick();
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output int lat);
    int n = 0;
    while (!in_ready16 && n < 50) begin tick(); n++; end
    a16 = x; b16 = y; in_valid16 = 1'b1; out_ready16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid16) begin lat = i; break; end
    end
    p = prod16;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready8); end
    checks++;
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
    checks++;
    if (prod8 !== 16'h0) begin errors++; $display("FAIL reset_prod got %h exp 0000", prod8); end
    checks++;
    if (prod16 !== 32'h0 || in_ready16 !== 1'b1) begin
      errors++; $display("FAIL reset_w16 got prod=%h rdy=%b exp 0/1", prod16, in_ready16);
    end
    checks++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency_allones();
    int n;
    a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
      errors++; $display("FAIL run_flags got busy=%b rdy=%b exp 1/0", busy8, in_ready8);
    end
    checks++;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid8) begin n = i; break; end
    end
    if (n !== LAT8) begin errors++; $display("FAIL latency8 got %0d exp %0d", n, LAT8); end
    checks++;
    if (prod8 !== 16'hFE01) begin errors++; $display("FAIL allones8 got %h exp fe01", prod8); end
    checks++;
    tick();
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL post_handshake got vld=%b rdy=%b exp 0/1", out_valid8, in_ready8);
    end
    checks++;
  endtask

  task automatic test_random8();
    logic [7:0]  xs [5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h80};
    logic [7:0]  ys [5] = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h02};
    logic [7:0]  x, y;
    logic [15:0] p, e;
    int lat;
    for (int i = 0; i < 21; i++) begin
      if (i < 5) begin x = xs[i]; y = ys[i]; end
      else begin x = 8'($urandom); y = 8'($urandom); end
`ifdef MULT_SIGNED_EN
      sm8 = 1'b0;
`endif
      e = 16'(x) * 16'(y);
      do_op8(x, y, p, lat);
      if (p !== e || lat !== LAT8) begin
        errors++; $display("FAIL mul8 %h*%h got %h lat %0d exp %h lat %0d", x, y, p, lat, e, LAT8);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready8 = 1'b1;
    a8 = 8'h00; b8 = 8'hA5; in_valid8 = 1'b1;
    tick();
    a8 = 8'h01; b8 = 8'hFF;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b exp 0", in_ready8); end
    checks++;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid8) begin n = i; break; end
    end
    if (prod8 !== 16'h0000 || n !== LAT8) begin
      errors++; $display("FAIL b2b_first got %h lat %0d exp 0000 lat %0d", prod8, n, LAT8);
    end
    checks++;
    tick();
    if (in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got rdy=%b busy=%b exp 1/0", in_ready8, busy8);
    end
    checks++;
    tick();
    in_valid8 = 1'b0;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b exp 1", busy8); end
    checks++;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid8) begin n = i; break; end
    end
    if (prod8 !== 16'h00FF || n !== LAT8) begin
      errors++; $display("FAIL b2b_second got %h lat %0d exp 00ff lat %0d", prod8, n, LAT8);
    end
    checks++;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    a8 = 8'd13; b8 = 8'd11; in_valid8 = 1'b1; out_ready8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_valid8) begin n = i; break; end
    end
    if (n !== LAT8) begin errors++; $display("FAIL bp_latency got %0d exp %0d", n, LAT8); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid8 !== 1'b1 || prod8 !== 16'd143) begin
        errors++; $display("FAIL bp_hold cyc %0d got vld=%b prod=%0d exp 1/143", i, out_valid8, prod8);
      end
      checks++;
    end
    out_ready8 = 1'b1;
    tick();
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", out_valid8); end
    checks++;
  endtask

  task automatic test_reset_midop();
    a8 = 8'd200; b8 = 8'd3; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || prod8 !== 16'h0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got rdy=%b vld=%b prod=%h busy=%b exp 1/0/0000/0",
               in_ready8, out_valid8, prod8, busy8);
    end
    checks++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid8 !== 1'b0) begin errors++; $display("FAIL midop_no_output cyc %0d got %b exp 0", i, out_valid8); end
      checks++;
    end
  endtask

  task automatic test_w16();
    logic [15:0] x, y;
    logic [31:0] p, e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; end
      else begin x = 16'($urandom); y = 16'($urandom); end
`ifdef MULT_SIGNED_EN
      sm16 = 1'b0;
`endif
      e = 32'(x) * 32'(y);
      do_op16(x, y, p, lat);
      if (p !== e || lat !== LAT16) begin
        errors++; $display("FAIL mul16 %h*%h got %h lat %0d exp %h lat %0d", x, y, p, lat, e, LAT16);
      end
      checks++;
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [7:0]  xs [3] = '{8'h80, 8'hFF, 8'hFF};
    logic [7:0]  ys [3] = '{8'h80, 8'h01, 8'h01};
    logic        ms [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  x, y;
    logic signed [15:0] sx, sy;
    logic [15:0] p, e;
    int lat;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin x = xs[i]; y = ys[i]; sm8 = ms[i]; end
      else begin x = 8'($urandom); y = 8'($urandom); sm8 = 1'($urandom); end
      sx = $signed(x); sy = $signed(y);
      e = sm8 ? 16'(sx * sy) : 16'(x) * 16'(y);
      do_op8(x, y, p, lat);
      if (p !== e || lat !== LAT8) begin
        errors++; $display("FAIL signed8 m=%b %h*%h got %h lat %0d exp %h", sm8, x, y, p, lat, e);
      end
      checks++;
    end
    sm8 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0;
`ifdef MULT_SIGNED_EN
    sm8 = 1'b0; sm16 = 1'b0;
`endif
    test_reset();
    test_latency_allones();
    test_random8();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_w16();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
